// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl_pkg
//  Description : Shared clock package. Holds the counter-select codes, the
//                edit FSM state encoding and small helpers for time_set_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_set_ctrl_pkg;

  // Field-select code presented to the counter chain
  typedef logic [2:0] sel_t;

  localparam sel_t SELECT_NONE  = 3'b000;
  localparam sel_t SELECT_MIN   = 3'b001;
  localparam sel_t SELECT_HOUR  = 3'b010;
  localparam sel_t SELECT_DAY   = 3'b011;
  localparam sel_t SELECT_MONTH = 3'b100;
  localparam sel_t SELECT_YEAR  = 3'b101;

  // State codes match the select codes of the field being edited
  typedef enum logic [2:0] {
    ST_RUN  = 3'b000,
    ST_MIN  = 3'b001,
    ST_HOUR = 3'b010,
    ST_DAY  = 3'b011,
    ST_MON  = 3'b100,
    ST_YEAR = 3'b101
  } state_t;

  // Mode-button order: RUN -> HOUR -> MIN -> DAY -> MON -> YEAR -> RUN
  function automatic state_t next_item(input state_t s);
    case (s)
      ST_RUN:  return ST_HOUR;
      ST_HOUR: return ST_MIN;
      ST_MIN:  return ST_DAY;
      ST_DAY:  return ST_MON;
      ST_MON:  return ST_YEAR;
      default: return ST_RUN;
    endcase
  endfunction

  // Field presented to the counters while in a given state
  function automatic sel_t sel_of(input state_t s);
    case (s)
      ST_HOUR: return SELECT_HOUR;
      ST_MIN:  return SELECT_MIN;
      ST_DAY:  return SELECT_DAY;
      ST_MON:  return SELECT_MONTH;
      ST_YEAR: return SELECT_YEAR;
      default: return SELECT_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl_if
//  Description : Button inputs and counter-control outputs of time_set_ctrl.
//                slave = controller side, master = button/counter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;
  import time_set_ctrl_pkg::*;

  logic btn_mode;
  logic btn_up;
  logic btn_down;
  sel_t select_item;
  logic up;
  logic down;
  logic en_1;
  logic sec_clr;
  logic blink;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  select_item, up, down, en_1, sec_clr, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output select_item, up, down, en_1, sec_clr, blink
  );

endinterface
`default_nettype wire

// File: rtl/time_set_ctrl_btn_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat
//  Description : Rising-edge detect plus auto-repeat for one debounced button.
//                o_fire is high on the press cycle and, once the button has
//                been held REPEAT_DLY cycles past the press, every cycle
//                until release. A button already high when reset releases is
//                ignored until it has been seen low once.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_repeat #(
  parameter int REPEAT_DLY = 3
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_btn,
  input  wire logic i_cancel,
  output logic      o_fire
);

  localparam int CNT_W = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
  localparam logic [CNT_W-1:0] c_dly = CNT_W'(REPEAT_DLY);

  logic             r_prev;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_rep;

  assign w_rise = i_btn & ~r_prev & r_armed;
  assign w_rep  = i_btn & r_armed & ~w_rise & (r_cnt == c_dly);
  assign o_fire = (w_rise | w_rep) & ~i_cancel;

  // Edge history, arming after a seen release, and held-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_prev <= i_btn;
      if (!i_btn) begin
        r_armed <= 1'b1;
      end
      if (!i_btn || i_cancel || !r_armed) begin
        r_cnt <= '0;
      end else if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != c_dly) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl
//  Description : Time-setting controller. Steps through the editable fields
//                on mode presses, issues up/down pulses (with auto-repeat)
//                to the selected counter, freezes the time while editing and
//                falls back to RUN after TIMEOUT idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 30,
  parameter int REPEAT_DLY = 3
) (
  input wire logic     clk_1Hz,
  input wire logic     rst,
  time_set_ctrl_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] c_idle_max = IDLE_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  sel_t              r_sel;
  logic              r_up;
  logic              r_down;
  logic              r_en;
  logic              r_sec_clr;
  logic              r_blink;
  logic [IDLE_W-1:0] r_idle;
  logic              r_mode_prev;
  logic              r_mode_armed;

  logic w_mode_edge;
  logic w_both;
  logic w_up_fire;
  logic w_down_fire;
  logic w_edit;
  logic w_change;

  // Mode is edge-only; a press held through reset is ignored until released
  assign w_mode_edge = bus.btn_mode & ~r_mode_prev & r_mode_armed;
  assign w_both      = bus.btn_up & bus.btn_down;
  assign w_edit      = (r_state != ST_RUN);
  assign w_change    = (w_next != r_state);

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_rep_up (
    .clk      (clk_1Hz),
    .rst      (rst),
    .i_btn    (bus.btn_up),
    .i_cancel (w_both),
    .o_fire   (w_up_fire)
  );

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_rep_down (
    .clk      (clk_1Hz),
    .rst      (rst),
    .i_btn    (bus.btn_down),
    .i_cancel (w_both),
    .o_fire   (w_down_fire)
  );

  // FSM state register
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: mode press advances, idle timeout forces RUN
  always_comb begin
    w_next = r_state;
    if (w_mode_edge) begin
      w_next = next_item(r_state);
    end else if (w_edit && (r_idle == c_idle_max)) begin
      w_next = ST_RUN;
    end
  end

  // Registered outputs, idle counter and mode edge history
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      r_sel        <= SELECT_NONE;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_en         <= 1'b1;
      r_sec_clr    <= 1'b0;
      r_blink      <= 1'b1;
      r_idle       <= '0;
      r_mode_prev  <= 1'b0;
      r_mode_armed <= 1'b0;
    end else begin
      r_mode_prev <= bus.btn_mode;
      if (!bus.btn_mode) begin
        r_mode_armed <= 1'b1;
      end
      r_sel     <= sel_of(w_next);
      // Pulses only in a steady edit state; a state change swallows them
      r_up      <= w_edit & ~w_change & w_up_fire;
      r_down    <= w_edit & ~w_change & w_down_fire;
      r_en      <= (w_next == ST_RUN);
      r_sec_clr <= w_edit & (w_next == ST_RUN);
      if (w_next == ST_RUN) begin
        r_blink <= 1'b1;
      end else if (!w_edit) begin
        r_blink <= 1'b0;
      end else begin
        r_blink <= ~r_blink;
      end
      if ((w_next == ST_RUN) || w_mode_edge || w_up_fire || w_down_fire) begin
        r_idle <= '0;
      end else if (r_idle != c_idle_max) begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  assign bus.select_item = r_sel;
  assign bus.up          = r_up;
  assign bus.down        = r_down;
  assign bus.en_1        = r_en;
  assign bus.sec_clr     = r_sec_clr;
  assign bus.blink       = r_blink;

endmodule
`default_nettype wire
